// File: rtl/alu_pkg.sv
// Shared types and widths for the two-requester ALU sharing arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// Contents: data/opcode widths, ALU opcode enum, arbiter FSM state enum,
// and the captured-request bundle carried from a requester to the shared ALU.
package alu_pkg;

   localparam int XLEN = 32;
   localparam int OPW  = 4;

   // Opcode encoding understood by the shared ALU. Codes 10..15 are not
   // listed; the arbiter forwards them untouched and the ALU answers 0.
   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRA  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Operation captured at accept time and replayed onto the ALU port.
   // The opcode is kept as raw bits so unlisted codes survive unchanged.
   typedef struct packed {
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [OPW-1:0]  op;
      logic            unsign;
   } alu_req_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant: one-hot grant among valid requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports:
//   req  [1:0] in  - request vector, bit N = requester N valid
//   last       in  - index of the requester served most recently
//   gnt  [1:0] out - one-hot grant, 0 when nobody requests
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Tie: favour whoever was not served most recently.
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters, one op at a time.
// Latency: accept at cycle T, response valid at T+2; new accept no earlier than T+3.
// Backpressure: response held stable until the owner's rsp ready; no accepts meanwhile.
//
// Ports:
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o   - request handshake for requester N (N=0,1)
//   reqN_rs1_i, reqN_rs2_i        - 32-bit operands of requester N
//   reqN_op_i, reqN_unsign_i      - opcode and unsigned flag of requester N
//   rspN_valid_o / rspN_ready_i   - response handshake for requester N
//   rspN_data_o                   - result for requester N (0 unless it owns RESP)
//   alu_rs1_o, alu_rs2_o          - operands to the shared ALU
//   alu_op_o, alu_unsign_o        - opcode / unsigned flag to the shared ALU
//   alu_rd_i                      - combinational ALU result
//   busy_o                        - high whenever the FSM is not idle
module alu_share_arb
   import alu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [XLEN-1:0] req0_rs1_i,
   input  logic [XLEN-1:0] req0_rs2_i,
   input  logic [OPW-1:0]  req0_op_i,
   input  logic            req0_unsign_i,
   output logic            rsp0_valid_o,
   output logic [XLEN-1:0] rsp0_data_o,
   input  logic            rsp0_ready_i,

   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [XLEN-1:0] req1_rs1_i,
   input  logic [XLEN-1:0] req1_rs2_i,
   input  logic [OPW-1:0]  req1_op_i,
   input  logic            req1_unsign_i,
   output logic            rsp1_valid_o,
   output logic [XLEN-1:0] rsp1_data_o,
   input  logic            rsp1_ready_i,

   output logic [XLEN-1:0] alu_rs1_o,
   output logic [XLEN-1:0] alu_rs2_o,
   output logic [OPW-1:0]  alu_op_o,
   output logic            alu_unsign_o,
   input  logic [XLEN-1:0] alu_rd_i,

   output logic            busy_o
);

   arb_state_e      state_q,  state_d;
   logic            last_q,   last_d;    // 1 = requester 1 served most recently
   alu_req_t        req_q,    req_d;
   logic            owner_q,  owner_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [1:0]      gnt;
   logic            accept;
   logic            owner_rsp_rdy;
   alu_req_t        req0_bundle;
   alu_req_t        req1_bundle;

   assign req0_bundle = '{rs1: req0_rs1_i, rs2: req0_rs2_i,
                          op: req0_op_i, unsign: req0_unsign_i};
   assign req1_bundle = '{rs1: req1_rs1_i, rs2: req1_rs2_i,
                          op: req1_op_i, unsign: req1_unsign_i};

   rr_arb2 u_rr_arb2 (
      .req  ({req1_valid_i, req0_valid_i}),
      .last (last_q),
      .gnt  (gnt)
   );

   // A grant already implies the matching valid, so any grant in IDLE is an accept.
   assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);

   // Only the owner's consume counts; the other requester's rsp ready is ignored.
   assign owner_rsp_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      req_d    = req_q;
      owner_d  = owner_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               req_d   = gnt[1] ? req1_bundle : req0_bundle;
               owner_d = gnt[1];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = alu_rd_i;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            // The fairness pointer moves only once the response is consumed,
            // so a stalled response does not change who wins the next tie.
            if (owner_rsp_rdy) begin
               last_d  = owner_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;     // requester 0 wins the first tie
         req_q    <= '0;
         owner_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         req_q    <= req_d;
         owner_q  <= owner_d;
         result_q <= result_d;
      end
   end

   // Ready is also gated by reset so nothing is offered while reset is held,
   // even if a requester keeps valid high through it.
   assign req0_ready_o = rst_ni && (state_q == ST_IDLE) && gnt[0];
   assign req1_ready_o = rst_ni && (state_q == ST_IDLE) && gnt[1];

   assign rsp0_valid_o = (state_q == ST_RESP) && !owner_q;
   assign rsp1_valid_o = (state_q == ST_RESP) &&  owner_q;
   assign rsp0_data_o  = rsp0_valid_o ? result_q : '0;
   assign rsp1_data_o  = rsp1_valid_o ? result_q : '0;

   // The ALU port always reflects the captured operation; consumers only
   // care about it during EXEC, when the result is sampled.
   assign alu_rs1_o    = req_q.rs1;
   assign alu_rs2_o    = req_q.rs2;
   assign alu_op_o     = req_q.op;
   assign alu_unsign_o = req_q.unsign;

   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU attached to the alu_* port.
// Latency: checks accept at T, EXEC at T+1, response at T+2.
// Backpressure: holds rsp ready low for several cycles and checks stability.
module tb_alu_share_arb;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req0_valid, req0_ready, req0_unsign, rsp0_valid, rsp0_ready;
   logic [31:0] req0_rs1, req0_rs2, rsp0_data;
   logic [3:0]  req0_op;
   logic        req1_valid, req1_ready, req1_unsign, rsp1_valid, rsp1_ready;
   logic [31:0] req1_rs1, req1_rs2, rsp1_data;
   logic [3:0]  req1_op;
   logic [31:0] alu_rs1, alu_rs2, alu_rd;
   logic [3:0]  alu_op;
   logic        alu_unsign;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req0_valid_i  (req0_valid),
      .req0_ready_o  (req0_ready),
      .req0_rs1_i    (req0_rs1),
      .req0_rs2_i    (req0_rs2),
      .req0_op_i     (req0_op),
      .req0_unsign_i (req0_unsign),
      .rsp0_valid_o  (rsp0_valid),
      .rsp0_data_o   (rsp0_data),
      .rsp0_ready_i  (rsp0_ready),
      .req1_valid_i  (req1_valid),
      .req1_ready_o  (req1_ready),
      .req1_rs1_i    (req1_rs1),
      .req1_rs2_i    (req1_rs2),
      .req1_op_i     (req1_op),
      .req1_unsign_i (req1_unsign),
      .rsp1_valid_o  (rsp1_valid),
      .rsp1_data_o   (rsp1_data),
      .rsp1_ready_i  (rsp1_ready),
      .alu_rs1_o     (alu_rs1),
      .alu_rs2_o     (alu_rs2),
      .alu_op_o      (alu_op),
      .alu_unsign_o  (alu_unsign),
      .alu_rd_i      (alu_rd),
      .busy_o        (busy)
   );

   // External ALU: unlisted opcodes return 0.
   always_comb begin
      alu_rd = 32'd0;
      case (alu_op)
         4'd0: alu_rd = alu_rs1 + alu_rs2;
         4'd1: alu_rd = alu_rs1 - alu_rs2;
         4'd2: alu_rd = alu_rs1 << alu_rs2[4:0];
         4'd3: alu_rd = {31'd0, ($signed(alu_rs1) < $signed(alu_rs2))};
         4'd4: alu_rd = {31'd0, (alu_rs1 < alu_rs2)};
         4'd5: alu_rd = alu_rs1 ^ alu_rs2;
         4'd6: alu_rd = 32'($signed(alu_rs1) >>> alu_rs2[4:0]);
         4'd7: alu_rd = alu_rs1 >> alu_rs2[4:0];
         4'd8: alu_rd = alu_rs1 | alu_rs2;
         4'd9: alu_rd = alu_rs1 & alu_rs2;
         default: alu_rd = 32'd0;
      endcase
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk1 ({tag, "_rdy0"},  req0_ready, 1'b0);
      chk1 ({tag, "_rdy1"},  req1_ready, 1'b0);
      chk1 ({tag, "_rv0"},   rsp0_valid, 1'b0);
      chk1 ({tag, "_rv1"},   rsp1_valid, 1'b0);
      chk32({tag, "_rd0"},   rsp0_data, 32'd0);
      chk32({tag, "_rd1"},   rsp1_data, 32'd0);
      chk32({tag, "_ars1"},  alu_rs1, 32'd0);
      chk32({tag, "_ars2"},  alu_rs2, 32'd0);
      chk32({tag, "_aop"},   {28'd0, alu_op}, 32'd0);
      chk1 ({tag, "_auns"},  alu_unsign, 1'b0);
      chk1 ({tag, "_busy"},  busy, 1'b0);
   endtask

   task automatic drv0(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic u);
      req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_unsign = u;
   endtask

   task automatic drv1(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic u);
      req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_unsign = u;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drv0(1'b1, ALU_ADD, 32'd9, 32'd9, 1'b1);   // valid held during reset must not be offered
      drv1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1 chk_all_zero("rst_hold");
      drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk_all_zero("rst_rel");

      // ---- req0 ADD 5,7 after reset ----
      @(negedge clk); drv0(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0);
      #1 chk1("t1_rdy0", req0_ready, 1'b1);
      chk1("t1_rdy1", req1_ready, 1'b0);
      chk1("t1_idle", busy, 1'b0);
      @(negedge clk); drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk1("t1_exec_busy", busy, 1'b1);
      chk1("t1_exec_rv0", rsp0_valid, 1'b0);
      chk1("t1_exec_rv1", rsp1_valid, 1'b0);
      chk32("t1_alu_rs1", alu_rs1, 32'd5);
      chk32("t1_alu_rs2", alu_rs2, 32'd7);
      @(negedge clk);
      #1 chk1("t1_rv0", rsp0_valid, 1'b1);
      chk32("t1_data0", rsp0_data, 32'd12);
      chk1("t1_rv1", rsp1_valid, 1'b0);
      chk32("t1_data1", rsp1_data, 32'd0);
      rsp0_ready = 1'b1;
      @(negedge clk); rsp0_ready = 1'b0;
      #1 chk1("t1_done_busy", busy, 1'b0);
      chk1("t1_done_rv0", rsp0_valid, 1'b0);
      chk1("t1_done_rv1", rsp1_valid, 1'b0);

      // ---- backpressure: req1 SLT -1,1 held for 4 cycles ----
      @(negedge clk); drv1(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
      #1 chk1("bp_rdy1", req1_ready, 1'b1);
      chk1("bp_rdy0", req0_ready, 1'b0);
      @(negedge clk);
      drv1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      drv0(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0);
      rsp0_ready = 1'b1;   // non-owner consume must be ignored
      #1 chk1("bp_exec_rdy0", req0_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk1($sformatf("bp_hold%0d_rv1", i), rsp1_valid, 1'b1);
         chk32($sformatf("bp_hold%0d_data1", i), rsp1_data, 32'd1);
         chk1($sformatf("bp_hold%0d_busy", i), busy, 1'b1);
         chk1($sformatf("bp_hold%0d_rdy0", i), req0_ready, 1'b0);
         chk1($sformatf("bp_hold%0d_rdy1", i), req1_ready, 1'b0);
         chk1($sformatf("bp_hold%0d_rv0", i), rsp0_valid, 1'b0);
      end
      @(negedge clk);
      drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      #1 chk1("bp_rel_rv1", rsp1_valid, 1'b1);
      @(negedge clk); rsp1_ready = 1'b0;
      #1 chk1("bp_idle_busy", busy, 1'b0);
      chk1("bp_idle_rv1", rsp1_valid, 1'b0);

      // ---- tie: req0 SUB 10,3 vs req1 AND F0,3C ----
      @(negedge clk);
      drv0(1'b1, ALU_SUB, 32'd10, 32'd3, 1'b0);
      drv1(1'b1, ALU_AND, 32'h0000_00F0, 32'h0000_003C, 1'b0);
      #1 chk1("tie1_rdy0", req0_ready, 1'b1);
      chk1("tie1_rdy1", req1_ready, 1'b0);
      @(negedge clk); drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk1("tie1_exec_rdy1", req1_ready, 1'b0);
      @(negedge clk);
      #1 chk1("tie1_rv0", rsp0_valid, 1'b1);
      chk32("tie1_data0", rsp0_data, 32'd7);
      chk1("tie1_rv1", rsp1_valid, 1'b0);
      chk1("tie1_resp_rdy1", req1_ready, 1'b0);
      rsp0_ready = 1'b1;
      @(negedge clk); rsp0_ready = 1'b0;
      #1 chk1("tie1_next_rdy1", req1_ready, 1'b1);
      chk1("tie1_next_rdy0", req0_ready, 1'b0);
      @(negedge clk); drv1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk1("tie1_r1_busy", busy, 1'b1);
      @(negedge clk);
      #1 chk1("tie1_r1_rv1", rsp1_valid, 1'b1);
      chk32("tie1_r1_data1", rsp1_data, 32'h0000_0030);
      chk32("tie1_r1_data0", rsp0_data, 32'd0);
      rsp1_ready = 1'b1;
      @(negedge clk); rsp1_ready = 1'b0;
      // second tie goes back to req0
      drv0(1'b1, ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 1'b1);
      drv1(1'b1, ALU_OR, 32'd1, 32'd2, 1'b0);
      #1 chk1("tie2_rdy0", req0_ready, 1'b1);
      chk1("tie2_rdy1", req1_ready, 1'b0);
      @(negedge clk);
      drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      drv1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk1("tie2_alu_uns", alu_unsign, 1'b1);
      chk32("tie2_alu_op", {28'd0, alu_op}, 32'd5);
      @(negedge clk);
      #1 chk1("tie2_rv0", rsp0_valid, 1'b1);
      chk32("tie2_data0", rsp0_data, 32'h0000_00F0);
      rsp0_ready = 1'b1;

      // ---- reset while in EXEC ----
      @(negedge clk); rsp0_ready = 1'b0;
      drv0(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
      #1 chk1("mr_rdy0", req0_ready, 1'b1);
      @(negedge clk);
      drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      rst_n = 1'b0;
      #1 chk_all_zero("mr_rst");
      @(negedge clk); rst_n = 1'b1;
      #1 chk_all_zero("mr_rel");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1 chk1($sformatf("mr_after%0d_rv0", i), rsp0_valid, 1'b0);
         chk1($sformatf("mr_after%0d_busy", i), busy, 1'b0);
      end

      // ---- tie after reset goes to req0; op 12 passes through ----
      @(negedge clk);
      drv0(1'b1, 4'd12, 32'h0000_1234, 32'd5, 1'b0);
      drv1(1'b1, ALU_ADD, 32'd3, 32'd4, 1'b0);
      #1 chk1("op12_rdy0", req0_ready, 1'b1);
      chk1("op12_rdy1", req1_ready, 1'b0);
      @(negedge clk);
      drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      drv1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk32("op12_alu_op", {28'd0, alu_op}, 32'd12);
      @(negedge clk);
      #1 chk1("op12_rv0", rsp0_valid, 1'b1);
      chk32("op12_data0", rsp0_data, 32'd0);
      rsp0_ready = 1'b1;

      // ---- operand capture: rs1 changes after accept ----
      @(negedge clk); rsp0_ready = 1'b0;
      drv0(1'b1, ALU_ADD, 32'd100, 32'd23, 1'b0);
      #1 chk1("cap_rdy0", req0_ready, 1'b1);
      @(negedge clk); drv0(1'b1, ALU_ADD, 32'd999, 32'd23, 1'b0);
      #1 chk32("cap_alu_rs1", alu_rs1, 32'd100);
      @(negedge clk); drv0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      #1 chk1("cap_rv0", rsp0_valid, 1'b1);
      chk32("cap_data0", rsp0_data, 32'd123);
      rsp0_ready = 1'b1;
      @(negedge clk); rsp0_ready = 1'b0;
      #1 chk1("cap_done_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameters: none. Widths are fixed at 32-bit data and a 4-bit opcode.
REQ-002 clk_i  in  1  Single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  Asynchronous, active-low reset.
REQ-004 reqN_valid_i  in  1  (N=0,1) Requester N presents an operation.
REQ-005 reqN_ready_o  out  1  Block accepts requester N's operation this cycle.
REQ-006 reqN_rs1_i, reqN_rs2_i  in  32  Operands of requester N.
REQ-007 reqN_op_i  in  4  ALU opcode of requester N (0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRA, 7 SRL, 8 OR, 9 AND).
REQ-008 reqN_unsign_i  in  1  Unsigned-compare/shift flag of requester N.
REQ-009 rspN_valid_o  out  1  Result available for requester N.
REQ-010 rspN_data_o  out  32  Result for requester N.
REQ-011 rspN_ready_i  in  1  Requester N consumes the result.
REQ-012 alu_rs1_o, alu_rs2_o  out  32  Operands driven to the shared ALU.
REQ-013 alu_op_o  out  4  Opcode driven to the shared ALU.
REQ-014 alu_unsign_o  out  1  Unsigned flag driven to the shared ALU.
REQ-015 alu_rd_i  in  32  Combinational ALU result.
REQ-016 busy_o  out  1  High whenever state is not IDLE.

Function
REQ-017 States: IDLE, EXEC, RESP. The FSM SHALL be encoded as a 2-bit enum.
REQ-018 In IDLE, the block SHALL assert reqN_ready_o only for the granted requester; the other ready SHALL be 0.
REQ-019 Grant rule in IDLE: only one valid requester → that requester is granted; both valid → the requester not served last is granted; neither valid → no grant.
REQ-020 The last-served pointer SHALL update only on the RESP→IDLE transition.
REQ-021 On reqN_valid_i && reqN_ready_o, the block SHALL capture rs1, rs2, op, unsign and the owner ID into registers and move to EXEC.
REQ-022 In EXEC, the alu_* outputs SHALL be driven from the captured registers. At the end of EXEC, alu_rd_i SHALL be captured into the result register and the FSM SHALL move to RESP.
REQ-023 Outside EXEC, the alu_* outputs SHALL hold the captured register values; their value is don't-care to consumers.
REQ-024 In RESP, rspN_valid_o SHALL be 1 only for the owner, and rspN_data_o SHALL equal the result register. Non-owner data SHALL read 0.
REQ-025 In RESP, if rspN_ready_i is 1 the FSM SHALL move to IDLE; otherwise it SHALL hold RESP, with valid and data stable.
REQ-026 Latency: accept at cycle T → rsp valid at T+2. Minimum issue interval is 3 cycles.
REQ-027 No request SHALL be accepted in EXEC or RESP; both ready outputs SHALL be 0 in those states.
REQ-028 A requester that deasserts valid before it is accepted SHALL lose nothing and SHALL NOT be granted.
REQ-029 Opcodes 10–15 SHALL be passed through unchanged. The result is whatever the ALU returns (0), with no error flag.
REQ-030 The non-owner requester's rsp ready SHALL be ignored.

Reset
REQ-031 Asserting rst_ni low at any time SHALL force IDLE, clear all operand, op, unsign, owner and result registers to 0, and set the last-served pointer to 1, so req0 wins the first tie.
REQ-032 During and immediately after reset, all outputs SHALL be 0: ready, rsp valid/data, alu_*, busy_o.
REQ-033 A transaction in progress when reset is asserted SHALL be dropped; no response SHALL be issued for it after reset.

Structure
REQ-034 A shared package alu_pkg SHALL hold:
  - the alu_op_e enum (values per REQ-007),
  - the arb_state_e enum,
  - localparams XLEN=32 and OPW=4.
REQ-035 The 2-requester round-robin grant logic SHALL be a sub-module rr_arb2 with:
  - inputs: req[1:0], last;
  - output: one-hot gnt[1:0].
REQ-036 The ALU SHALL be instantiated outside this block, not inside it.

Verification
REQ-037 Reset check: after reset, drive req0 ADD 5,7 → req0_ready_o=1 at accept (cycle T); rsp0_valid_o=1 with rsp0_data_o=12 at T+2; rsp1_valid_o=0 throughout.
REQ-038 Tie and alternation check: both valid (req0 SUB 10,3; req1 AND 0xF0,0x3C) and held → req0 served first (data 7), then req1 (data 0x30); a second tie → req0 served again.
REQ-039 Backpressure check: req1 SLT 0xFFFFFFFF,1 with rsp1_ready_i=0 for 4 cycles → rsp1_valid_o held at 1 with data=1 and busy_o=1; no ready asserted on either requester; release → IDLE the next cycle.
REQ-040 Reset mid-transaction check: accept req0, assert rst_ni low in EXEC → all outputs 0; after release, no rsp0_valid_o; the next tie goes to req0.
REQ-041 Opcode and operand capture check: req0 op 12 → rsp data 0 at T+2. Also, changing req0_rs1_i after accept SHALL NOT alter the result.
